// File: rtl/dac_seq_pkg.sv
// Shared types and next-code arithmetic for the DAC ramp sequencer.
// The widths here are the defaults that the sequencer parameters take.
package dac_seq_pkg;

    localparam int SEQ_CODE_W  = 8;
    localparam int SEQ_STEP_W  = 4;
    localparam int SEQ_DWELL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_DWELL  = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [SEQ_CODE_W-1:0]  target;
        logic [SEQ_STEP_W-1:0]  step;
        logic [SEQ_DWELL_W-1:0] dwell;
    } seq_cmd_t;

    // Moves toward tgt by min(step, distance). A step of zero jumps straight to tgt.
    // The move is clamped to the distance, so the result cannot wrap.
    function automatic logic [SEQ_CODE_W-1:0] next_code(
        input logic [SEQ_CODE_W-1:0] cur,
        input logic [SEQ_CODE_W-1:0] tgt,
        input logic [SEQ_STEP_W-1:0] step
    );
        logic                  up;
        logic [SEQ_CODE_W-1:0] delta;
        logic [SEQ_CODE_W-1:0] step_ext;
        logic [SEQ_CODE_W-1:0] mv;
        up       = (tgt >= cur);
        step_ext = {{(SEQ_CODE_W-SEQ_STEP_W){1'b0}}, step};
        if (up) begin
            delta = tgt - cur;
        end else begin
            delta = cur - tgt;
        end
        if ((step == {SEQ_STEP_W{1'b0}}) || (step_ext > delta)) begin
            mv = delta;
        end else begin
            mv = step_ext;
        end
        if (up) begin
            return cur + mv;
        end else begin
            return cur - mv;
        end
    endfunction

endpackage

// File: rtl/dac_dwell_timer.sv
// Loadable down-counter that holds each ramp step for a programmed number of cycles.
module dac_dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    // Load takes priority over decrement. The count holds at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != {W{1'b0}})) begin
            r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == {W{1'b0}});

endmodule

// File: rtl/dac_ramp_sequencer.sv
// Walks the DAC code toward a commanded target in programmable steps.
// Each step is held for a programmable dwell, and completion is signalled with a one-cycle done pulse.
module dac_ramp_sequencer
    import dac_seq_pkg::*;
#(
    parameter int                 CODE_W     = SEQ_CODE_W,
    parameter int                 STEP_W     = SEQ_STEP_W,
    parameter int                 DWELL_W    = SEQ_DWELL_W,
    parameter logic [CODE_W-1:0]  RESET_CODE = {CODE_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CODE_W-1:0]  cmd_target,
    input  logic [STEP_W-1:0]  cmd_step,
    input  logic [DWELL_W-1:0] cmd_dwell,
    output logic [CODE_W-1:0]  dac_code,
    output logic               dac_update,
    output logic               busy,
    output logic               done
);

    seq_state_e        r_state;
    seq_cmd_t          r_cmd;
    logic [CODE_W-1:0] r_code;
    logic              r_update;
    logic              r_done;
    logic              r_ready;
    logic              r_busy;

    logic              w_accept;
    logic              w_at_target;
    logic              w_load;
    logic              w_dec;
    logic              w_expired;
    logic [CODE_W-1:0] w_next;

    assign w_accept    = cmd_valid && r_ready;
    assign w_at_target = (r_code == r_cmd.target);
    assign w_next      = next_code(r_code, r_cmd.target, r_cmd.step);
    assign w_load      = (r_state == ST_STEP) && !w_at_target;
    assign w_dec       = (r_state == ST_DWELL);

    dac_dwell_timer #(.W(DWELL_W)) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (r_cmd.dwell),
        .i_dec      (w_dec),
        .o_expired  (w_expired)
    );

    // Expiry of a dwell always returns to STEP. STEP then decides whether the ramp is finished,
    // so done lands one STEP cycle after the last dwell.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cmd.target <= {CODE_W{1'b0}};
            r_cmd.step   <= {STEP_W{1'b0}};
            r_cmd.dwell  <= {DWELL_W{1'b0}};
            r_code       <= RESET_CODE;
            r_update     <= 1'b0;
            r_done       <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_update <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd.target <= cmd_target;
                        r_cmd.step   <= cmd_step;
                        r_cmd.dwell  <= cmd_dwell;
                        r_ready      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_STEP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (w_at_target) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_code   <= w_next;
                        r_update <= 1'b1;
                        r_state  <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (w_expired) begin
                        r_state <= ST_STEP;
                    end else begin
                        r_state <= ST_DWELL;
                    end
                end
                ST_FINISH: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = r_ready;
    assign busy       = r_busy;
    assign dac_code   = r_code;
    assign dac_update = r_update;
    assign done       = r_done;

endmodule
